// File: rtl/fork_join_sched.sv
// Fork/join job launcher: starts NUM_JOBS countdown jobs on one command and raises one join event per launch.
// Optional abort input and kill logic are built only when FJ_ABORT_EN is defined.
module fork_join_sched #(
   parameter int NUM_JOBS = 3,
   parameter int CNT_W    = 8,
   parameter int ELAP_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [NUM_JOBS*CNT_W-1:0] dur_i,
`ifdef FJ_ABORT_EN
   input  logic                      abort,
`endif
   output logic                      busy,
   output logic [NUM_JOBS-1:0]       job_active,
   output logic [NUM_JOBS-1:0]       job_done_pulse,
   output logic                      join_done,
   output logic [ELAP_W-1:0]         elapsed
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [1:0] M_ANY  = 2'b01;
   localparam logic [1:0] M_NONE = 2'b10;

   logic [0:0]          state_q,   state_d;
   logic [1:0]          mode_q,    mode_d;
   logic                joined_q,  joined_d;
   logic [CNT_W-1:0]    cnt_q [NUM_JOBS];
   logic [CNT_W-1:0]    cnt_d [NUM_JOBS];
   logic [ELAP_W-1:0]   elapsed_q, elapsed_d;
   logic [NUM_JOBS-1:0] active_q,  active_d;
   logic [NUM_JOBS-1:0] pulse_q,   pulse_d;
   logic                busy_q,    busy_d;
   logic                join_q,    join_d;

   logic [NUM_JOBS-1:0] expire_s;
   logic [NUM_JOBS-1:0] remain_s;
   logic                fire_s;

   // Jobs whose counter reaches zero on the coming edge, and those still running after it.
   always_comb begin
      expire_s = '0;
      for (int i = 0; i < NUM_JOBS; i++) begin
         expire_s[i] = (cnt_q[i] == CNT_W'(1));
      end
      remain_s = active_q & ~expire_s;
   end

   // Next-state logic for launch, countdown, completion and join tracking.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      joined_d  = joined_q;
      elapsed_d = elapsed_q;
      active_d  = active_q;
      busy_d    = busy_q;
      pulse_d   = '0;
      join_d    = 1'b0;
      fire_s    = 1'b0;
      for (int i = 0; i < NUM_JOBS; i++) begin
         cnt_d[i] = cnt_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               mode_d    = mode;
               joined_d  = 1'b0;
               elapsed_d = '0;
               active_d  = '1;
               busy_d    = 1'b1;
               // A zero duration still runs for one cycle.
               for (int i = 0; i < NUM_JOBS; i++) begin
                  if (dur_i[i*CNT_W +: CNT_W] == '0) begin
                     cnt_d[i] = CNT_W'(1);
                  end else begin
                     cnt_d[i] = dur_i[i*CNT_W +: CNT_W];
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
`ifdef FJ_ABORT_EN
            if (abort) begin
               state_d  = S_IDLE;
               active_d = '0;
               busy_d   = 1'b0;
               for (int i = 0; i < NUM_JOBS; i++) begin
                  cnt_d[i] = '0;
               end
               // The joiner still learns of termination if it has not fired yet.
               join_d   = ~joined_q;
               joined_d = 1'b1;
            end else
`endif
            begin
               for (int i = 0; i < NUM_JOBS; i++) begin
                  if (cnt_q[i] != '0) begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end else begin
                     cnt_d[i] = cnt_q[i];
                  end
               end
               if (elapsed_q == {ELAP_W{1'b1}}) begin
                  elapsed_d = elapsed_q;
               end else begin
                  elapsed_d = elapsed_q + ELAP_W'(1);
               end
               active_d = remain_s;
               busy_d   = |remain_s;
               pulse_d  = active_q & expire_s;
               if (remain_s == '0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_RUN;
               end

               case (mode_q)
                  M_ANY:   fire_s = |expire_s;
                  M_NONE:  fire_s = 1'b1;
                  default: fire_s = (remain_s == '0);
               endcase
               if (fire_s && !joined_q) begin
                  join_d   = 1'b1;
                  joined_d = 1'b1;
               end else begin
                  join_d   = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= 2'b00;
         joined_q  <= 1'b0;
         elapsed_q <= '0;
         active_q  <= '0;
         pulse_q   <= '0;
         busy_q    <= 1'b0;
         join_q    <= 1'b0;
         for (int i = 0; i < NUM_JOBS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         joined_q  <= joined_d;
         elapsed_q <= elapsed_d;
         active_q  <= active_d;
         pulse_q   <= pulse_d;
         busy_q    <= busy_d;
         join_q    <= join_d;
         for (int i = 0; i < NUM_JOBS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign busy           = busy_q;
   assign job_active     = active_q;
   assign job_done_pulse = pulse_q;
   assign join_done      = join_q;
   assign elapsed        = elapsed_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// Bench for fork_join_sched: directed scenarios plus random traffic against a launch-relative timing model.
module tb_fork_join_sched;
   localparam int NJ = 3;
   localparam int CW = 8;
   localparam int EW = 16;
`ifdef FJ_ABORT_EN
   localparam bit AB_EN = 1'b1;
`else
   localparam bit AB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, start, abort;
   logic [1:0]       mode;
   logic [NJ*CW-1:0] dur_i;
   logic             busy, join_done;
   logic [NJ-1:0]    job_active, job_done_pulse;
   logic [EW-1:0]    elapsed;

   fork_join_sched #(.NUM_JOBS(NJ), .CNT_W(CW), .ELAP_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dur_i(dur_i),
`ifdef FJ_ABORT_EN
      .abort(abort),
`endif
      .busy(busy), .job_active(job_active), .job_done_pulse(job_done_pulse),
      .join_done(join_done), .elapsed(elapsed)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: everything is expressed as edge count k since the launch edge.
   bit have_run = 1'b0;
   bit aborted  = 1'b0;
   int k = 0, end_k = 0, kj = 0, maxd = 0;
   int d[NJ];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k, $time);
      end
   endtask

   task automatic cycle(input bit rn, input bit st, input logic [1:0] md,
                        input logic [NJ*CW-1:0] dv, input bit ab);
      int mn;
      logic [NJ-1:0] e_act, e_pls;
      logic e_busy, e_join;
      @(negedge clk);
      rst_n = rn; start = st; mode = md; dur_i = dv; abort = ab;
      @(posedge clk);
      if (!rn) begin
         have_run = 1'b0;
      end else if (!have_run || k >= end_k) begin
         if (st) begin
            have_run = 1'b1; aborted = 1'b0; k = 0;
            maxd = 0; mn = 1000;
            for (int i = 0; i < NJ; i++) begin
               d[i] = int'(dv[i*CW +: CW]);
               if (d[i] == 0) d[i] = 1;
               if (d[i] > maxd) maxd = d[i];
               if (d[i] < mn) mn = d[i];
            end
            end_k = maxd;
            kj = (md == 2'b01) ? mn : (md == 2'b10) ? 1 : maxd;
         end else begin
            k++;
         end
      end else begin
         k++;
         if (ab && AB_EN) begin
            aborted = 1'b1;
            end_k = k;
         end
      end
      #1;
      e_act = '0; e_pls = '0; e_busy = 1'b0; e_join = 1'b0;
      if (have_run) begin
         for (int i = 0; i < NJ; i++) begin
            e_act[i] = (k < d[i]) && (k < end_k);
            e_pls[i] = (k == d[i]) && (!aborted || d[i] < end_k);
         end
         e_busy = (k < end_k);
         e_join = ((k == kj) && (!aborted || kj < end_k)) ||
                  (aborted && k == end_k && kj >= end_k);
      end
      check_val("job_active", job_active, e_act);
      check_val("job_done_pulse", job_done_pulse, e_pls);
      check_val("busy", busy, e_busy);
      check_val("join_done", join_done, e_join);
      if (!have_run) check_val("elapsed", elapsed, 0);
      else if (!aborted) check_val("elapsed", elapsed, (k < maxd) ? k : maxd);
   endtask

   function automatic logic [NJ*CW-1:0] rand_dur(input int hi);
      logic [NJ*CW-1:0] v;
      for (int i = 0; i < NJ; i++) v[i*CW +: CW] = CW'($urandom_range(0, hi));
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) cycle(1'b1, 1'b0, 2'($urandom), rand_dur(255), 1'b0);
   endtask

   task automatic launch(input logic [1:0] md, input logic [NJ*CW-1:0] dv, input int n);
      cycle(1'b1, 1'b1, md, dv, 1'b0);
      idle(n);
   endtask

   localparam logic [NJ*CW-1:0] D345 = {8'd50, 8'd40, 8'd30};

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; dur_i = '0;
      repeat (2) cycle(1'b0, 1'b1, 2'b00, D345, 1'b1);
      launch(2'b00, D345, 55);                       // join-all
      launch(2'b01, D345, 55);                       // join-any
      launch(2'b10, D345, 55);                       // join-none
      launch(2'b11, D345, 55);                       // mode 11 behaves as join-all
      launch(2'b01, {8'd0, 8'd5, 8'd5}, 8);          // zero duration as one cycle
      launch(2'b10, {8'd1, 8'd0, 8'd1}, 4);          // join-none coincident with all done
      // Back-to-back: start held on the return edge must be ignored, next one accepted.
      cycle(1'b1, 1'b1, 2'b00, {8'd2, 8'd2, 8'd2}, 1'b0);
      repeat (4) cycle(1'b1, 1'b1, 2'b00, {8'd3, 8'd1, 8'd2}, 1'b0);
      idle(4);
      // Restart ignored mid-run, then reset kills the run silently.
      cycle(1'b1, 1'b1, 2'b00, D345, 1'b0);
      idle(9);
      cycle(1'b1, 1'b1, 2'b01, {8'd1, 8'd1, 8'd1}, 1'b0);
      idle(9);
      cycle(1'b0, 1'b0, 2'b00, '0, 1'b0);
      idle(2);
      launch(2'b00, {8'd7, 8'd3, 8'd9}, 12);
      // Abort during join-all run (no effect on the model when the port is absent).
      cycle(1'b1, 1'b1, 2'b00, D345, 1'b0);
      idle(34);
      cycle(1'b1, 1'b0, 2'b00, '0, 1'b1);
      idle(4);
      cycle(1'b1, 1'b1, 2'b01, D345, 1'b1);         // abort in IDLE with start launches
      idle(3);
      cycle(1'b1, 1'b0, 2'b00, '0, 1'b1);
      idle(3);
      // Random traffic.
      repeat (3000) begin
         cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), 2'($urandom),
               ($urandom_range(0, 9) == 0) ? rand_dur(255) : rand_dur(12),
               ($urandom_range(0, 24) == 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
